// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter sharing one UART transmit line among
// NUM_REQ byte requesters. Frames are start + DATA_WIDTH data bits (LSB first)
// + STOP_BITS stop bits, timed by an upstream OVERSAMPLE-x baud_tick pulse.
module uart_tx_scheduler #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int OVERSAMPLE = 16,
   parameter int STOP_BITS  = 1,
   localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          Clk,
   input  logic                          Reset,
   input  logic                          baud_tick,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [IDW-1:0]                grant_id
);

   localparam int TCW   = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int BCW   = $clog2(DATA_WIDTH + STOP_BITS + 1);
   // Requester slots padded to a power of two so the index never runs off the end.
   localparam int NSLOT = 1 << IDW;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                r_state;
   logic                  r_tx;
   logic                  r_busy;
   logic [IDW-1:0]        r_grant_id;
   logic [IDW-1:0]        r_rr_ptr;
   logic [TCW-1:0]        r_tick_cnt;
   logic [BCW-1:0]        r_bit_cnt;
   logic [DATA_WIDTH-1:0] r_shift;

   logic [NSLOT-1:0]      w_valid_ext;
   logic [DATA_WIDTH-1:0] w_data_slot [NSLOT];
   logic                  w_found;
   logic [IDW-1:0]        w_winner;
   logic [IDW-1:0]        w_rr_next;
   logic                  w_bit_end;
   logic [DATA_WIDTH-1:0] w_shift_next;

   genvar gi;

   generate
      for (gi = 0; gi < NSLOT; gi++) begin : g_slot
         if (gi < NUM_REQ) begin : g_used
            assign w_valid_ext[gi] = req_valid[gi];
            assign w_data_slot[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
         end else begin : g_pad
            assign w_valid_ext[gi] = 1'b0;
            assign w_data_slot[gi] = '0;
         end
      end
   endgenerate

   // Round-robin search: first valid requester at or above rr_ptr, wrapping.
   always_comb begin
      logic [IDW-1:0] v_idx;
      w_found  = 1'b0;
      w_winner = '0;
      v_idx    = r_rr_ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!w_found && w_valid_ext[v_idx]) begin
            w_found  = 1'b1;
            w_winner = v_idx;
         end
         v_idx = (v_idx == IDW'(NUM_REQ - 1)) ? '0 : v_idx + IDW'(1);
      end
   end

   assign w_rr_next    = (w_winner == IDW'(NUM_REQ - 1)) ? '0 : w_winner + IDW'(1);
   assign w_bit_end    = baud_tick && (r_tick_cnt == TCW'(OVERSAMPLE - 1));
   assign w_shift_next = r_shift >> 1;

   // Accept pulse only while idle; suppressed during reset so no byte is
   // handed over that the reset would then drop.
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
         assign req_ready[gi] = (r_state == IDLE) && w_found && !Reset &&
                                (w_winner == IDW'(gi));
      end
   endgenerate

   // Frame sequencer: grant latch, bit timing, and registered line/busy outputs.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state    <= IDLE;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
         r_grant_id <= '0;
         r_rr_ptr   <= '0;
         r_tick_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
      end else begin
         if (r_state != IDLE && baud_tick) begin
            r_tick_cnt <= w_bit_end ? '0 : r_tick_cnt + TCW'(1);
         end
         case (r_state)
            IDLE: begin
               r_tx       <= 1'b1;
               r_busy     <= 1'b0;
               r_tick_cnt <= '0;
               r_bit_cnt  <= '0;
               if (w_found) begin
                  r_shift    <= w_data_slot[w_winner];
                  r_grant_id <= w_winner;
                  r_rr_ptr   <= w_rr_next;
                  r_state    <= START;
                  r_tx       <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            START: begin
               if (w_bit_end) begin
                  r_state   <= DATA;
                  r_bit_cnt <= '0;
                  r_tx      <= r_shift[0];
               end
            end
            DATA: begin
               if (w_bit_end) begin
                  if (r_bit_cnt == BCW'(DATA_WIDTH - 1)) begin
                     r_state   <= STOP;
                     r_bit_cnt <= '0;
                     r_tx      <= 1'b1;
                  end else begin
                     r_shift   <= w_shift_next;
                     r_bit_cnt <= r_bit_cnt + BCW'(1);
                     r_tx      <= w_shift_next[0];
                  end
               end
            end
            STOP: begin
               if (w_bit_end) begin
                  if (r_bit_cnt == BCW'(STOP_BITS - 1)) begin
                     r_state   <= IDLE;
                     r_bit_cnt <= '0;
                     r_busy    <= 1'b0;
                     r_tx      <= 1'b1;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + BCW'(1);
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign tx       = r_tx;
   assign busy     = r_busy;
   assign grant_id = r_grant_id;

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares one UART transmit line between NUM_REQ byte requesters. Arbitration is round-robin. Each granted byte is serialized as an 8N1-style frame (start, DATA_WIDTH data bits LSB first, STOP_BITS stop bits). Bit timing comes from the existing 16x oversampled baud_tick pulse generator, which sits upstream; this block sequences the line using those ticks.

Parameters:
NUM_REQ, 4, number of requester channels (>=1)
DATA_WIDTH, 8, bits per frame payload
OVERSAMPLE, 16, baud_tick pulses per bit period
STOP_BITS, 1, stop bits per frame (1 or 2)

Ports:
Clk  input  1  system clock
Reset  input  1  synchronous active-high reset
baud_tick  input  1  single-cycle pulse from baud generator, OVERSAMPLE per bit
req_valid  input  NUM_REQ  per-requester byte valid
req_data  input  NUM_REQ*DATA_WIDTH  requester i byte at [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  output  NUM_REQ  one-hot accept pulse; transfer occurs when valid&ready
tx  output  1  serial line, idle high
busy  output  1  high while a frame is in progress
grant_id  output  max(1,$clog2(NUM_REQ))  index of requester owning current/last frame

Behaviour:
- One clock (Clk); reset is synchronous and active-high (Reset). All state updates on posedge Clk.
- Reset values: tx=1, busy=0, req_ready=0, grant_id=0, rr_ptr=0, tick_cnt=0, bit_cnt=0, state=IDLE.
- Reset asserted mid-frame aborts the frame: tx=1 and state=IDLE from the next edge. The partial byte is dropped and not retried.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: tx=1, busy=0. If any req_valid, the winner is the first set bit scanning from rr_ptr upward with wrap.
  - Same cycle (combinational from registered state): req_ready[winner]=1; all other ready bits are 0.
  - Next edge: latch req_data[winner] into shift register, grant_id<=winner, rr_ptr<=(winner+1) mod NUM_REQ, tick_cnt<=0, state<=START.
- req_ready is asserted only in IDLE and only for one cycle per grant. It is never asserted to a requester with valid low.
- Bit timing: tick_cnt increments on each baud_tick while not IDLE. A bit period ends on the baud_tick where tick_cnt==OVERSAMPLE-1; tick_cnt then wraps to 0. Cycles without baud_tick hold all counters.
- START: tx=0 for one bit period, then DATA with bit_cnt=0.
- DATA: tx=shift[0]. At bit end, shift right and bit_cnt++. After bit DATA_WIDTH-1 ends, go to STOP.
- STOP: tx=1 for STOP_BITS bit periods, then IDLE.
- Frame length: exactly (1+DATA_WIDTH+STOP_BITS)*OVERSAMPLE baud_ticks.
- tx changes the cycle after the registering edge. It is glitch-free and registered.
- busy=1 in START/DATA/STOP. grant_id holds its value after the frame until the next grant.
- Earliest next grant is the first cycle in IDLE after STOP, giving a minimum 1-cycle idle gap (not a tick gap).
- req_valid/req_data changes after acceptance are ignored for the current frame.
- baud_tick in IDLE is ignored; tick_cnt stays 0.
- Simultaneous requests: round-robin guarantees each persistent requester is served within NUM_REQ frames.
- NUM_REQ=1: grant_id is a constant 0 and the arbiter degenerates to pass-through.

Test Plan:
- Single frame: req 0 sends 0xA5, baud_tick every cycle, default params -> req_ready[0] pulses once; tx sequence 0,1,0,1,0,0,1,0,1,1, each level held 16 cycles; busy high 160 cycles; grant_id=0.
- Round-robin: all 4 req_valid held high with distinct bytes 0x11/0x22/0x33/0x44 -> grants in order 0,1,2,3,0; each frame contains its requester's byte; never two ready bits high at once.
- Sparse ticks: baud_tick every 3rd cycle, byte 0xFF -> frame lasts 480 cycles (+/-2 alignment); tx low for exactly the start bit.
- Reset mid-frame: assert Reset during data bit 3 for 1 cycle -> next cycle tx=1, busy=0, req_ready=0, rr_ptr=0. A new request then gets grant 0 and a full correct frame.
- rr_ptr fairness: req 2 valid alone, then reqs 1 and 3 valid together -> grant 2, then 3, then 1.
- STOP_BITS=2, byte 0x00 -> tx high for 32 ticks at frame end; total 176 ticks; next grant no earlier than the cycle after.
